// File: rtl/subbank_pkg.sv
// subbank_pkg: shared helpers and types for the sub-bank line memory.
//   div_ceil      integer ceiling division
//   uram_bits     width of the URAM stripe (low bits of a line)
//   bram_bits     width of the BRAM stripe (remaining high bits)
//   seg_depth     depth of one segment of a stripe split across tiles
//   idx_bits      bits needed to index n items (never less than 1)
//   state_t       clear-sweep FSM states (INIT, RUN)
//   RD_LAT_MIN/MAX  supported read latency range
package subbank_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int div_ceil(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int uram_bits(input int line, input int utiles, input int btiles);
    return (line * utiles) / (utiles + btiles);
  endfunction

  function automatic int bram_bits(input int line, input int utiles, input int btiles);
    return line - uram_bits(line, utiles, btiles);
  endfunction

  function automatic int seg_depth(input int depth, input int tiles);
    return div_ceil(depth, tiles);
  endfunction

  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subbank_seg_ram.sv
// subbank_seg_ram: one depth segment of a stripe. Simple dual port,
// per-bit write enable, registered read (read-first on address collision).
//   clk    clock
//   we     write enable
//   be     per-bit write enable, WIDTH bits
//   waddr  segment-local write address
//   wdata  write data, WIDTH bits
//   re     read enable; rdata only changes on a read
//   raddr  segment-local read address
//   rdata  registered read data, WIDTH bits
// STYLE selects the inferred memory primitive: "ultra" or "block".
module subbank_seg_ram
  import subbank_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter int    DEPTH = 64,
  parameter string STYLE = "block",
  localparam int   AW    = idx_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] be,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Both branches are identical apart from the primitive hint; the read
  // sits in the same block as the write so a colliding read sees old data.
  if (STYLE == "ultra") begin : g_ultra
    (* ram_style = "ultra" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (re) begin
        rdata <= mem[raddr];
      end
      if (we) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (be[i]) begin
            mem[waddr][i] <= wdata[i];
          end
        end
      end
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (re) begin
        rdata <= mem[raddr];
      end
      if (we) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (be[i]) begin
            mem[waddr][i] <= wdata[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/subbank_mem_pipe.sv
// subbank_mem_pipe: DEPTH x LINE_WIDTH sub-bank line memory, one write and
// one read port. Low bits live in a URAM stripe, high bits in a BRAM18
// stripe; each stripe is split by depth into segments. A clear sweep zeroes
// every line after reset before user traffic is accepted.
//   clk, rst    clock, synchronous active-high reset
//   we, wmask, waddr, wdata   write port, wmask bit i enables coefficient i
//   re, raddr   read request
//   rdata, rvalid   read line and strobe, RD_LAT cycles after re
//   init_busy   clear sweep running, we/re ignored
//   parity_err  per-coefficient parity mismatch on the returned line
// Optional feature: define SUBBANK_PARITY_EN to store one even-parity bit
// per coefficient in an extra BRAM column; otherwise parity_err is 0.
module subbank_mem_pipe
  import subbank_pkg::*;
#(
  parameter int  COEFF_BITS       = 50,
  parameter int  COEFFS_PER_BLOCK = 8,
  parameter int  DEPTH            = 1024,
  parameter int  URAM_TILES       = 3,
  parameter int  BRAM18_TILES     = 13,
  parameter int  RD_LAT           = 2,
  localparam int LINE_WIDTH       = COEFF_BITS * COEFFS_PER_BLOCK,
  localparam int ADDR_W           = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [COEFFS_PER_BLOCK-1:0] wmask,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [LINE_WIDTH-1:0]       wdata,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           raddr,
  output logic [LINE_WIDTH-1:0]       rdata,
  output logic                        rvalid,
  output logic                        init_busy,
  output logic                        parity_err
);

  localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int U_BITS = uram_bits(LINE_WIDTH, URAM_TILES, BRAM18_TILES);
  localparam int B_BITS = bram_bits(LINE_WIDTH, URAM_TILES, BRAM18_TILES);
  localparam int U_SEG  = seg_depth(DEPTH, URAM_TILES);
  localparam int B_SEG  = seg_depth(DEPTH, BRAM18_TILES);
  localparam int U_IW   = idx_bits(URAM_TILES);
  localparam int B_IW   = idx_bits(BRAM18_TILES);
  localparam int U_OW   = idx_bits(U_SEG);
  localparam int B_OW   = idx_bits(B_SEG);
`ifdef SUBBANK_PARITY_EN
  localparam int B_COL  = B_BITS + COEFFS_PER_BLOCK;
`else
  localparam int B_COL  = B_BITS;
`endif

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;

  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [LINE_WIDTH-1:0]       wr_data;
  logic [LINE_WIDTH-1:0]       wr_be;
  logic [COEFFS_PER_BLOCK-1:0] wr_mask;
  logic [U_IW-1:0]             w_useg, r_useg;
  logic [B_IW-1:0]             w_bseg, r_bseg;
  logic [U_OW-1:0]             w_uoff, r_uoff;
  logic [B_OW-1:0]             w_boff, r_boff;
  logic                        rd_acc, rd_oob;

  logic [B_COL-1:0]  b_wdata, b_be;
  logic [U_BITS-1:0] u_rdata [URAM_TILES];
  logic [B_COL-1:0]  b_rdata [BRAM18_TILES];

  logic                  s1_valid, s1_oob, s1_perr;
  logic [U_IW-1:0]       s1_useg;
  logic [B_IW-1:0]       s1_bseg;
  logic [LINE_WIDTH-1:0] s1_line;

`ifdef SUBBANK_PARITY_EN
  function automatic logic [COEFFS_PER_BLOCK-1:0] coeff_parity(input logic [LINE_WIDTH-1:0] line);
    logic [COEFFS_PER_BLOCK-1:0] p;
    for (int i = 0; i < COEFFS_PER_BLOCK; i++) begin
      p[i] = ^line[i*COEFF_BITS +: COEFF_BITS];
    end
    return p;
  endfunction
`endif

  // Sweep state and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // INIT visits every line once; the last line hands over to RUN.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign init_busy = (state == INIT);

  // Write source: the sweep owns the port in INIT, the user in RUN.
  // Out-of-range user writes are simply not enabled.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    wr_mask = wmask;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = '0;
      wr_mask = '1;
    end else begin
      wr_en   = we && !rst && ({1'b0, waddr} < (ADDR_W + 1)'(DEPTH));
    end
    for (int i = 0; i < LINE_WIDTH; i++) begin
      wr_be[i] = wr_mask[i / COEFF_BITS];
    end
  end

  // Address decode into segment index and segment-local offset per stripe.
  always_comb begin
    w_useg = U_IW'(32'(wr_addr) / 32'(U_SEG));
    w_uoff = U_OW'(32'(wr_addr) % 32'(U_SEG));
    w_bseg = B_IW'(32'(wr_addr) / 32'(B_SEG));
    w_boff = B_OW'(32'(wr_addr) % 32'(B_SEG));
    r_useg = U_IW'(32'(raddr) / 32'(U_SEG));
    r_uoff = U_OW'(32'(raddr) % 32'(U_SEG));
    r_bseg = B_IW'(32'(raddr) / 32'(B_SEG));
    r_boff = B_OW'(32'(raddr) % 32'(B_SEG));
  end

  assign rd_acc = re && !rst && (state == RUN);
  assign rd_oob = !({1'b0, raddr} < (ADDR_W + 1)'(DEPTH));

`ifdef SUBBANK_PARITY_EN
  assign b_wdata = {coeff_parity(wr_data), wr_data[LINE_WIDTH-1:U_BITS]};
  assign b_be    = {wr_mask, wr_be[LINE_WIDTH-1:U_BITS]};
`else
  assign b_wdata = wr_data[LINE_WIDTH-1:U_BITS];
  assign b_be    = wr_be[LINE_WIDTH-1:U_BITS];
`endif

  for (genvar k = 0; k < URAM_TILES; k++) begin : g_uram
    subbank_seg_ram #(
      .WIDTH (U_BITS),
      .DEPTH (U_SEG),
      .STYLE ("ultra")
    ) u_seg (
      .clk   (clk),
      .we    (wr_en && (w_useg == U_IW'(k))),
      .be    (wr_be[U_BITS-1:0]),
      .waddr (w_uoff),
      .wdata (wr_data[U_BITS-1:0]),
      .re    (rd_acc && !rd_oob && (r_useg == U_IW'(k))),
      .raddr (r_uoff),
      .rdata (u_rdata[k])
    );
  end

  for (genvar k = 0; k < BRAM18_TILES; k++) begin : g_bram
    subbank_seg_ram #(
      .WIDTH (B_COL),
      .DEPTH (B_SEG),
      .STYLE ("block")
    ) u_seg (
      .clk   (clk),
      .we    (wr_en && (w_bseg == B_IW'(k))),
      .be    (b_be),
      .waddr (w_boff),
      .wdata (b_wdata),
      .re    (rd_acc && !rd_oob && (r_bseg == B_IW'(k))),
      .raddr (r_boff),
      .rdata (b_rdata[k])
    );
  end

  // Tags travel with the memory read so the output mux never looks at the
  // live raddr. Tags only move on an accepted read, so the selected segment
  // outputs (which also only move on reads) keep the mux output stable.
  // s1_oob resets high so the mux yields zero before the first read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b1;
      s1_useg  <= '0;
      s1_bseg  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_oob  <= rd_oob;
        s1_useg <= r_useg;
        s1_bseg <= r_bseg;
      end
    end
  end

  // Stitch the two stripes back into a line; out-of-range reads return zero.
  always_comb begin
    s1_line = '0;
    s1_perr = 1'b0;
    if (!s1_oob) begin
      s1_line = {b_rdata[s1_bseg][B_BITS-1:0], u_rdata[s1_useg]};
`ifdef SUBBANK_PARITY_EN
      s1_perr = |(b_rdata[s1_bseg][B_COL-1:B_BITS] ^ coeff_parity(s1_line));
`endif
    end
  end

  if (LAT == 1) begin : g_lat1
    assign rdata      = s1_line;
    assign rvalid     = s1_valid;
    assign parity_err = s1_valid & s1_perr;
  end else begin : g_pipe
    logic [LINE_WIDTH-1:0] p_data  [LAT-1];
    logic                  p_valid [LAT-1];
    logic                  p_perr  [LAT-1];

    // Data only advances with its valid, so the last stage holds rdata
    // between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < LAT - 1; j++) begin
          p_valid[j] <= 1'b0;
          p_data[j]  <= '0;
          p_perr[j]  <= 1'b0;
        end
      end else begin
        p_valid[0] <= s1_valid;
        if (s1_valid) begin
          p_data[0] <= s1_line;
          p_perr[0] <= s1_perr;
        end
        for (int j = 1; j < LAT - 1; j++) begin
          p_valid[j] <= p_valid[j-1];
          if (p_valid[j-1]) begin
            p_data[j] <= p_data[j-1];
            p_perr[j] <= p_perr[j-1];
          end
        end
      end
    end

    assign rdata      = p_data[LAT-2];
    assign rvalid     = p_valid[LAT-2];
    assign parity_err = p_valid[LAT-2] & p_perr[LAT-2];
  end

endmodule

// File: tb/tb_subbank_mem_pipe.sv
// tb_subbank_mem_pipe: directed self-checking bench for subbank_mem_pipe
// with default geometry (URAM segments of 342 lines, BRAM segments of 79).
// The parity scenario is compiled in when SUBBANK_PARITY_EN is defined.
module tb_subbank_mem_pipe;

  localparam int CB     = 50;
  localparam int NC     = 8;
  localparam int LW     = CB * NC;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [NC-1:0] wmask = '0;
  logic [9:0]    waddr = '0;
  logic [LW-1:0] wdata = '0;
  logic          re = 1'b0;
  logic [9:0]    raddr = '0;
  logic [LW-1:0] rdata;
  logic          rvalid;
  logic          init_busy;
  logic          parity_err;

  int checks = 0;
  int failures = 0;

  subbank_mem_pipe #(
    .COEFF_BITS       (CB),
    .COEFFS_PER_BLOCK (NC),
    .DEPTH            (DEPTH),
    .URAM_TILES       (3),
    .BRAM18_TILES     (13),
    .RD_LAT           (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .wmask      (wmask),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .init_busy  (init_busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Distinct pattern per seed, every coefficient different, upper bits set.
  function automatic logic [LW-1:0] pat(input int s);
    logic [LW-1:0] p;
    for (int i = 0; i < NC; i++) begin
      p[i*CB +: CB] = {18'(s * 7 + i + 1), 32'hA5A5_0000 ^ 32'(s * 16 + i)};
    end
    return p;
  endfunction

  function automatic logic [LW-1:0] merge(input logic [LW-1:0] old_l, input logic [LW-1:0] new_l,
                                          input logic [NC-1:0] m);
    logic [LW-1:0] r;
    r = old_l;
    for (int i = 0; i < NC; i++) begin
      if (m[i]) r[i*CB +: CB] = new_l[i*CB +: CB];
    end
    return r;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic write_line(input int a, input logic [NC-1:0] m, input logic [LW-1:0] d);
    we = 1'b1; waddr = 10'(a); wmask = m; wdata = d;
    @(negedge clk);
    we = 1'b0; wmask = '0;
  endtask

  // Issues one read and watches 8 cycles; lat is the first cycle with rvalid.
  task automatic read_line(input int a, output logic [LW-1:0] d, output logic pe, output int lat);
    re = 1'b1; raddr = 10'(a);
    lat = -1; d = '0; pe = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      re = 1'b0;
      if (rvalid && lat < 0) begin
        lat = k; d = rdata; pe = parity_err;
      end
    end
  endtask

  // Counts busy cycles starting at the negedge where rst was just dropped.
  task automatic count_sweep(input bit inject, output int n, output bit seen_rv);
    n = 0; seen_rv = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (inject && i == 100) begin
        we = 1'b1; wmask = '1; waddr = 10'd5; wdata = pat(9);
        re = 1'b1; raddr = 10'd5;
      end else if (inject && i == 101) begin
        we = 1'b0; re = 1'b0; wmask = '0;
      end
      if (rvalid) seen_rv = 1'b1;
      if (!init_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== '0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_err got=%b exp=0", parity_err); end
    checks++; if (init_busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_init_busy got=%b exp=1", init_busy); end
  endtask

  task automatic test_init_sweep();
    int n; bit seen; logic [LW-1:0] d; logic pe; int lat;
    rst = 1'b0;
    count_sweep(1'b1, n, seen);
    checks++; if (n !== DEPTH) begin failures++; $display("[TB] FAIL sweep_len got=%0d exp=%0d", n, DEPTH); end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL sweep_rvalid got=%b exp=0", seen); end
    read_line(5, d, pe, lat);
    checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL clear_read_lat got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (d !== '0) begin failures++; $display("[TB] FAIL clear_read_data got=%h exp=0", d); end
    checks++; if (pe !== 1'b0) begin failures++; $display("[TB] FAIL clear_read_perr got=%b exp=0", pe); end
  endtask

  task automatic test_full_write();
    logic [LW-1:0] d; logic pe; int lat;
    write_line(7, 8'hFF, pat(1));
    read_line(7, d, pe, lat);
    checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL full_write_lat got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (d !== pat(1)) begin failures++; $display("[TB] FAIL full_write_data got=%h exp=%h", d, pat(1)); end
  endtask

  task automatic test_masked_write();
    logic [LW-1:0] d, exp_l; logic pe; int lat;
    logic [NC-1:0] masks [3];
    masks[0] = 8'h01; masks[1] = 8'h02; masks[2] = 8'h00;
    exp_l = pat(1);
    for (int j = 0; j < 3; j++) begin
      write_line(7, masks[j], pat(2 + j));
      exp_l = merge(exp_l, pat(2 + j), masks[j]);
      read_line(7, d, pe, lat);
      checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL mask_lat[%0d] got=%0d exp=%0d", j, lat, RD_LAT); end
      checks++; if (d !== exp_l) begin failures++; $display("[TB] FAIL mask_data[%0d] got=%h exp=%h", j, d, exp_l); end
    end
  endtask

  task automatic test_back_to_back();
    int addrs [7];
    int got;
    logic [LW-1:0] last_l;
    addrs[0] = 63;  addrs[1] = 64;  addrs[2] = 1023; addrs[3] = 78;
    addrs[4] = 79;  addrs[5] = 341; addrs[6] = 342;
    for (int j = 0; j < 7; j++) write_line(addrs[j], 8'hFF, pat(10 + j));
    got = 0;
    last_l = '0;
    re = 1'b1; raddr = 10'(addrs[0]);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k < 7) raddr = 10'(addrs[k]); else re = 1'b0;
      if (rvalid) begin
        checks++;
        if (k - RD_LAT !== got) begin failures++; $display("[TB] FAIL b2b_slot[%0d] got_cycle=%0d exp_cycle=%0d", got, k, got + RD_LAT); end
        if (got < 7) begin
          last_l = pat(10 + got);
          checks++;
          if (rdata !== pat(10 + got)) begin failures++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", got, rdata, pat(10 + got)); end
        end
        got++;
      end
    end
    checks++; if (got !== 7) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=7", got); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== last_l) begin failures++; $display("[TB] FAIL b2b_hold got=%h exp=%h", rdata, last_l); end
  endtask

  task automatic test_same_cycle();
    logic [LW-1:0] d; logic pe; int lat;
    write_line(10, 8'hFF, pat(20));
    we = 1'b1; waddr = 10'd10; wmask = 8'hFF; wdata = pat(21);
    re = 1'b1; raddr = 10'd10;
    @(negedge clk);
    we = 1'b0; wmask = '0; re = 1'b0;
    lat = -1; d = '0;
    for (int k = 2; k <= 6; k++) begin
      if (rvalid && lat < 0) begin lat = k - 1; d = rdata; end
      @(negedge clk);
    end
    checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL rw_same_lat got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (d !== pat(20)) begin failures++; $display("[TB] FAIL rw_same_old got=%h exp=%h", d, pat(20)); end
    read_line(10, d, pe, lat);
    checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL rw_after_lat got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (d !== pat(21)) begin failures++; $display("[TB] FAIL rw_after_new got=%h exp=%h", d, pat(21)); end
  endtask

  task automatic test_reset_mid_sweep();
    int n; bit seen; logic [LW-1:0] d; logic pe; int lat;
    int addrs [3];
    addrs[0] = 7; addrs[1] = 1023; addrs[2] = 10;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (init_busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy got=%b exp=1", init_busy); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    count_sweep(1'b0, n, seen);
    checks++; if (n !== DEPTH) begin failures++; $display("[TB] FAIL mid_sweep_len got=%0d exp=%0d", n, DEPTH); end
    for (int j = 0; j < 3; j++) begin
      read_line(addrs[j], d, pe, lat);
      checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL cleared_lat[%0d] got=%0d exp=%0d", addrs[j], lat, RD_LAT); end
      checks++; if (d !== '0) begin failures++; $display("[TB] FAIL cleared_data[%0d] got=%h exp=0", addrs[j], d); end
    end
  endtask

`ifdef SUBBANK_PARITY_EN
  task automatic test_parity();
    logic [LW-1:0] d, exp_l; logic pe; int lat;
    write_line(3, 8'hFF, pat(30));
    read_line(3, d, pe, lat);
    checks++; if (pe !== 1'b0) begin failures++; $display("[TB] FAIL parity_clean got=%b exp=0", pe); end
    dut.g_uram[0].u_seg.g_ultra.mem[3][0] = ~dut.g_uram[0].u_seg.g_ultra.mem[3][0];
    exp_l = pat(30);
    exp_l[0] = ~exp_l[0];
    read_line(3, d, pe, lat);
    checks++; if (lat !== RD_LAT) begin failures++; $display("[TB] FAIL parity_lat got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (pe !== 1'b1) begin failures++; $display("[TB] FAIL parity_flag got=%b exp=1", pe); end
    checks++; if (d !== exp_l) begin failures++; $display("[TB] FAIL parity_data got=%h exp=%h", d, exp_l); end
  endtask
`endif

  initial begin
    test_reset();
    test_init_sweep();
    test_full_write();
    test_masked_write();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid_sweep();
`ifdef SUBBANK_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
